// File: rtl/keyb_pkg.sv
// Shared definitions for the 4x4 keypad emulator: state encoding, key limits and
// the code-to-matrix mapping (the inverse of the scan decoder's col*4 + row + 1).
package keyb_pkg;

    localparam logic [1:0] KEYB_IDLE  = 2'd0;
    localparam logic [1:0] KEYB_PRESS = 2'd1;
    localparam logic [1:0] KEYB_GAP   = 2'd2;

    localparam int KEY_NONE  = 0;
    localparam int KEY_MAX   = 16;
    localparam int KEYB_ROWS = 4;
    localparam int KEYB_COLS = 4;

    typedef struct packed {
        logic [1:0] col;
        logic [1:0] row;
    } key_pos_t;

    function automatic logic key_is_legal(input logic [5:0] code);
        return (code != 6'(KEY_NONE)) && (code <= 6'(KEY_MAX));
    endfunction

    // Only meaningful for legal codes 1..16; the index wraps harmlessly otherwise.
    function automatic key_pos_t key_to_pos(input logic [5:0] code);
        logic [3:0] idx;
        key_pos_t   pos;
        idx     = 4'(code - 6'd1);
        pos.col = idx[3:2];
        pos.row = idx[1:0];
        return pos;
    endfunction

endpackage

// File: rtl/keyb_hold_timer.sv
// Loadable down-counter with a zero flag, shared by the hold and gap phases.
module keyb_hold_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A load always wins over a decrement; the counter saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/keyb_matrix_emulator.sv
// Key injector: accepts key codes over valid/ready and answers the scanner's
// column strobes on the row lines for the programmed hold time, then releases.
module keyb_matrix_emulator
    import keyb_pkg::*;
#(
    parameter int HOLD_CYCLES = 64,
    parameter int GAP_CYCLES  = 32,
    parameter int CNT_W       = 16
) (
    input  logic                 Clock,
    input  logic                 Reset_N,
    input  logic [5:0]           Key_Code_I,
    input  logic                 Key_Valid_I,
    output logic                 Key_Ready_O,
    input  logic                 Abort_I,
    input  logic [KEYB_COLS-1:0] Keyb_Col_I,
    output logic [KEYB_ROWS-1:0] Keyb_Row_O,
    output logic                 Busy_O,
    output logic                 Err_O
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       row_q, row_d;
    logic [1:0]       col_q, col_d;
    logic             err_q, err_d;

    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             timer_dec;
    logic             timer_zero;
    logic             accept;
    key_pos_t         pos;

    assign accept = Key_Valid_I & Key_Ready_O;
    assign pos    = key_to_pos(Key_Code_I);

    keyb_hold_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i      (Clock),
        .rst_n_i    (Reset_N),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .dec_i      (timer_dec),
        .zero_o     (timer_zero)
    );

    // Abort and hold expiry share one path into GAP, so they can never double-load.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        err_d      = 1'b0;
        timer_load = 1'b0;
        timer_val  = '0;
        timer_dec  = 1'b0;
        case (state_q)
            KEYB_IDLE: begin
                if (accept) begin
                    if (key_is_legal(Key_Code_I)) begin
                        row_d      = pos.row;
                        col_d      = pos.col;
                        timer_load = 1'b1;
                        timer_val  = HOLD_LOAD;
                        state_d    = KEYB_PRESS;
                    end else if (Key_Code_I != 6'(KEY_NONE)) begin
                        err_d = 1'b1;
                    end
                end
            end
            KEYB_PRESS: begin
                if (Abort_I || timer_zero) begin
                    timer_load = 1'b1;
                    timer_val  = GAP_LOAD;
                    state_d    = KEYB_GAP;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            KEYB_GAP: begin
                if (timer_zero) begin
                    state_d = KEYB_IDLE;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            default: begin
                state_d = KEYB_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_N) begin
            state_q <= KEYB_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            err_q   <= err_d;
        end
    end

    // Rows follow the column strobe combinationally, like a real switch matrix.
    always_comb begin
        Keyb_Row_O = '0;
        if (state_q == KEYB_PRESS) begin
            Keyb_Row_O[row_q] = Keyb_Col_I[col_q];
        end
    end

    assign Key_Ready_O = (state_q == KEYB_IDLE);
    assign Busy_O      = (state_q != KEYB_IDLE);
    assign Err_O       = err_q;

endmodule

// File: doc/keyb_matrix_emulator.md
Name: keyb_matrix_emulator

Overview:
- Inverse of the keypad scan decoder. Accepts 6-bit key codes over a valid/ready handshake and "presses" the matching key for a programmed time.
- While a key is pressed, the block answers the scanner's one-hot column strobes on the row lines, exactly as a physical 4x4 keypad would.
- Used as a host-driven key injector (UART/debug path) and as the keypad model in decoder benches.

Parameters:
- HOLD_CYCLES, 64, clocks a key stays pressed; valid range 1..2^CNT_W-1.
- GAP_CYCLES, 32, clocks of forced release after each press; valid range 1..2^CNT_W-1.
- CNT_W, 16, width of the hold/gap counter.

Ports:
- Clock  in  1  system clock; all state updates on posedge.
- Reset_N  in  1  synchronous, active-low reset.
- Key_Code_I  in  6  key code: 1..16 = key, 0 = release command, 17..63 = illegal.
- Key_Valid_I  in  1  key code offered.
- Key_Ready_O  out  1  block accepts a code this cycle.
- Abort_I  in  1  cancel the current press.
- Keyb_Col_I  in  4  one-hot column strobe from the scanner.
- Keyb_Row_O  out  4  row lines returned to the scanner.
- Busy_O  out  1  a press or gap is in progress.
- Err_O  out  1  one-cycle pulse when an illegal code is accepted.

Behaviour:
- Reset: reset is synchronous, active-low (Reset_N = 0 at posedge). Reset values:
  - state = IDLE, counter = 0, latched row/column = 0.
  - Key_Ready_O = 1, Busy_O = 0, Err_O = 0, Keyb_Row_O = 0.
  - Reset during PRESS drops the rows on the first cycle after the reset edge.
- Code mapping: for code k in 1..16, col = (k-1)>>2 and row = (k-1)&3. This is the inverse of the decoder's value = col*4 + row + 1.
- Row output (combinational from registered state):
  - Keyb_Row_O[row] = (state == PRESS) & Keyb_Col_I[col]; all other row bits are 0.
  - Multi-hot or zero Keyb_Col_I is handled bitwise, with no special case. There is no registered stage, so the scanner samples the rows in the same cycle it drives the column.
- Handshake:
  - Transfer occurs when Key_Valid_I & Key_Ready_O at posedge.
  - Key_Ready_O = (state == IDLE), registered.
  - There is no queue; the host holds Key_Valid_I until the transfer.
- FSM:
  - IDLE:
    - Legal code 1..16 accepted: latch col/row, load counter = HOLD_CYCLES-1, go to PRESS.
    - Code 0 accepted: stay in IDLE, no effect.
    - Code 17..63 accepted: Err_O = 1 for one cycle, stay in IDLE.
  - PRESS: decrement counter each cycle; at counter == 0 load GAP_CYCLES-1 and go to GAP. Keyb_Row_O is active for exactly HOLD_CYCLES cycles.
  - GAP: rows 0, decrement counter; at counter == 0 go to IDLE. Key_Ready_O rises on the following cycle.
- Abort_I:
  - In PRESS: go to GAP next cycle (load GAP_CYCLES-1); rows drop the cycle after the abort edge.
  - In GAP or IDLE: ignored.
  - Abort_I and counter expiry in the same cycle: GAP is entered once, with the counter loaded from GAP_CYCLES-1.
- Busy_O = (state != IDLE).
- Counter arithmetic is unsigned CNT_W bits; no wrap is possible within the legal parameter range.
- Accept-to-next-accept period is HOLD_CYCLES + GAP_CYCLES + 1 cycles minimum.

Decomposition:
- Shared package keyb_pkg:
  - State encoding (KEYB_IDLE, KEYB_PRESS, KEYB_GAP).
  - KEY_NONE = 0, KEY_MAX = 16, KEYB_ROWS = 4, KEYB_COLS = 4.
  - Code-to-row/column mapping function, reused by the decoder bench.
- One sub-module: keyb_hold_timer (loadable down-counter with a zero flag), used for both the hold and gap phases.

Test Plan:
- Reset, then offer code 6 with Valid held, sweeping Col_I one-hot every cycle → accepted on the first posedge; Row_O = 4'b0010 only when Col_I = 4'b0010, for exactly 64 cycles; then 32 cycles of 0; Ready returns at cycle 97.
- Codes 1, 16, 0 and 17 in sequence → rows 0001@col0 and 1000@col3; code 0 gives no press and immediate Ready; code 17 gives a single-cycle Err_O and no press.
- Abort_I asserted 10 cycles into a press of code 11 → rows drop the next cycle, Busy_O stays 1 for 32 more cycles, and the next code is accepted afterwards.
- Abort_I asserted in the cycle the hold counter reaches 0 → a single GAP of exactly 32 cycles, no double entry.
- Reset_N pulled low mid-PRESS for 1 cycle → Row_O = 0, Ready = 1, Busy = 0 on the next cycle; a pending Valid is accepted afterwards.
- Closed loop with the keypad scan decoder, for codes 1..16 → the decoder output equals the injected code while pressed and returns to 0 after the gap.
